// File: rtl/franken_pkg.sv
// Shared definitions for the franken data-memory subsystem: MMIO offsets,
// STATUS bit layout and the UART transmitter state encoding.
`timescale 1ns/1ps
package franken_pkg;

  localparam logic [7:0] MMIO_TXDATA = 8'h00;
  localparam logic [7:0] MMIO_STATUS = 8'h04;
  localparam logic [7:0] MMIO_CYCLE  = 8'h08;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  function automatic logic [31:0] status_word(input logic full, input logic empty,
                                              input logic busy, input logic ovf);
    logic [31:0] w;
    w           = 32'd0;
    w[ST_FULL]  = full;
    w[ST_EMPTY] = empty;
    w[ST_BUSY]  = busy;
    w[ST_OVF]   = ovf;
    return w;
  endfunction

endpackage

// File: rtl/franken_uart_tx.sv
// 8N1 serial transmitter: baud counter plus IDLE/START/DATA/STOP FSM with a
// valid/ready byte input so a back-to-back byte is taken at the end of STOP.
`timescale 1ns/1ps
module franken_uart_tx
  import franken_pkg::*;
#(
  parameter int CLK_DIV = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       uart_tx,
  output logic       busy
);

  localparam int BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);

  uart_state_t   state_r, state_s;
  logic [BW-1:0] baud_r, baud_s;
  logic [2:0]    bit_r, bit_s;
  logic [7:0]    byte_r, byte_s;
  logic          tx_r, tx_s;
  logic          baud_done_s;

  assign baud_done_s = (baud_r == BAUD_LAST);
  assign in_ready    = (state_r == IDLE) | ((state_r == STOP) & baud_done_s);
  assign uart_tx     = tx_r;
  assign busy        = (state_r != IDLE);

  // Next-state, counters and the registered line level for the next cycle
  always_comb begin
    state_s = state_r;
    baud_s  = baud_r;
    bit_s   = bit_r;
    byte_s  = byte_r;
    tx_s    = tx_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_s = START;
          byte_s  = in_data;
          baud_s  = {BW{1'b0}};
          tx_s    = 1'b0;
        end else begin
          tx_s = 1'b1;
        end
      end
      START: begin
        if (baud_done_s) begin
          state_s = DATA;
          baud_s  = {BW{1'b0}};
          bit_s   = 3'd0;
          tx_s    = byte_r[0];
        end else begin
          baud_s = baud_r + BW'(1);
        end
      end
      DATA: begin
        if (baud_done_s) begin
          baud_s = {BW{1'b0}};
          if (bit_r == 3'd7) begin
            state_s = STOP;
            tx_s    = 1'b1;
          end else begin
            bit_s = bit_r + 3'd1;
            tx_s  = byte_r[bit_r + 3'd1];
          end
        end else begin
          baud_s = baud_r + BW'(1);
        end
      end
      STOP: begin
        if (baud_done_s) begin
          baud_s = {BW{1'b0}};
          bit_s  = 3'd0;
          // A waiting byte starts its start bit immediately, no idle gap
          if (in_valid) begin
            state_s = START;
            byte_s  = in_data;
            tx_s    = 1'b0;
          end else begin
            state_s = IDLE;
            tx_s    = 1'b1;
          end
        end else begin
          baud_s = baud_r + BW'(1);
        end
      end
      default: begin
        state_s = IDLE;
        baud_s  = {BW{1'b0}};
        bit_s   = 3'd0;
        tx_s    = 1'b1;
      end
    endcase
  end

  // FSM state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      baud_r  <= {BW{1'b0}};
      bit_r   <= 3'd0;
      byte_r  <= 8'd0;
      tx_r    <= 1'b1;
    end else begin
      state_r <= state_s;
      baud_r  <= baud_s;
      bit_r   <= bit_s;
      byte_r  <= byte_s;
      tx_r    <= tx_s;
    end
  end

endmodule

// File: rtl/franken_dmem_uart.sv
// Single-cycle data memory: byte-enabled word RAM plus an MMIO window with a
// FIFO-fed UART transmitter and a free-running cycle counter.
`timescale 1ns/1ps
module franken_dmem_uart
  import franken_pkg::*;
#(
  parameter int MEM_WORDS  = 1024,
  parameter int FIFO_DEPTH = 8,
  parameter int CLK_DIV    = 434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_write,
  input  logic [3:0]  byte_enable,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        uart_tx,
  output logic        tx_busy
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FIFO_FULL_CNT = CW'(FIFO_DEPTH);

  logic [31:0]   ram_r [MEM_WORDS];
  logic [7:0]    fifo_r [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_r, rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          ovf_r;
  logic [31:0]   cycle_r;

  logic [AW-1:0] ram_idx_s;
  logic [7:0]    offset_s;
  logic          is_mmio_s, ram_we_s, fifo_full_s, fifo_empty_s;
  logic          push_req_s, push_s, pop_s, ovf_set_s, ovf_clr_s;
  logic          uart_ready_s, uart_busy_s;
  logic          unused_s;

  assign ram_idx_s    = address[AW+1:2];
  assign is_mmio_s    = address[31];
  assign offset_s     = address[7:0];
  assign ram_we_s     = mem_write & ~is_mmio_s;
  assign fifo_full_s  = (count_r == FIFO_FULL_CNT);
  assign fifo_empty_s = (count_r == {CW{1'b0}});
  assign push_req_s   = mem_write & is_mmio_s & (offset_s == MMIO_TXDATA) & byte_enable[0];
  assign pop_s        = uart_ready_s & ~fifo_empty_s;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign push_s       = push_req_s & (~fifo_full_s | pop_s);
  assign ovf_set_s    = push_req_s & fifo_full_s & ~pop_s;
  assign ovf_clr_s    = mem_write & is_mmio_s & (offset_s == MMIO_STATUS) &
                        byte_enable[0] & write_data[ST_OVF];
  assign tx_busy      = uart_busy_s | ~fifo_empty_s;
  assign unused_s     = ^address;

  // Byte-lane RAM write; contents deliberately survive reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ram_we_s && byte_enable[i]) begin
        ram_r[ram_idx_s][8*i +: 8] <= write_data[8*i +: 8];
      end
    end
  end

  // TX FIFO storage
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_r[wr_ptr_r] <= write_data[7:0];
    end
  end

  // FIFO pointers, overflow flag and cycle counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      ovf_r    <= 1'b0;
      cycle_r  <= 32'd0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
      if (ovf_set_s) begin
        ovf_r <= 1'b1;
      end else if (ovf_clr_s) begin
        ovf_r <= 1'b0;
      end
      cycle_r <= cycle_r + 32'd1;
    end
  end

  // Same-cycle load mux; MMIO reads have no side effects
  always_comb begin
    read_data = 32'd0;
    if (!is_mmio_s) begin
      read_data = ram_r[ram_idx_s];
    end else begin
      case (offset_s)
        MMIO_TXDATA: read_data = 32'd0;
        MMIO_STATUS: read_data = status_word(fifo_full_s, fifo_empty_s, tx_busy, ovf_r);
        MMIO_CYCLE:  read_data = cycle_r;
        default:     read_data = 32'd0;
      endcase
    end
  end

  franken_uart_tx #(
    .CLK_DIV (CLK_DIV)
  ) u_uart_tx (
    .clk      (clk),
    .rst_n    (reset),
    .in_valid (~fifo_empty_s),
    .in_data  (fifo_r[rd_ptr_r]),
    .in_ready (uart_ready_s),
    .uart_tx  (uart_tx),
    .busy     (uart_busy_s)
  );

endmodule

// File: doc/franken_dmem_uart.md
Name: franken_dmem_uart

Overview:
- Data-memory subsystem downstream of the single-cycle core.
- Consumes the core's store strobe, byte enables, address (ALU result) and lane-aligned write data, and returns read data in the same cycle.
- Contains a byte-enabled word RAM plus a memory-mapped region holding:
  - an 8N1 UART transmitter with a TX FIFO
  - a free-running cycle counter
- The core cannot stall, so every access completes in one cycle; full-FIFO writes are dropped and flagged.

Parameters:
- MEM_WORDS, 1024, RAM depth in 32-bit words (power of two).
- FIFO_DEPTH, 8, TX FIFO entries (power of two, >=2).
- CLK_DIV, 434, clock cycles per UART bit (>=2).

Ports:
- clk  in  1  core clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- mem_write  in  1  store strobe from core.
- byte_enable  in  4  byte lane enables for stores.
- address  in  32  byte address (core ALU result).
- write_data  in  32  lane-aligned store data.
- read_data  out  32  combinational load data.
- uart_tx  out  1  serial output, idle high, registered.
- tx_busy  out  1  high while a frame is on the line or the FIFO is non-empty.

Behaviour:
- Decode by address[31]:
  - address[31]=0: RAM, word index address[log2(MEM_WORDS)+1:2]; upper bits ignored (aliasing).
  - address[31]=1: MMIO, offset address[7:0].
- RAM write:
  - Each lane i with mem_write & byte_enable[i] is written at posedge clk.
  - RAM is not cleared by reset.
- RAM read: asynchronous. read_data = RAM[index] in the same cycle. A read of the location written in that cycle returns the old contents.
- MMIO map:
  - 0x00 TXDATA:
    - Write with byte_enable[0]=1 pushes write_data[7:0].
    - Write with byte_enable[0]=0 is ignored.
    - Reads return 0.
  - 0x04 STATUS (read): bit0 fifo_full, bit1 fifo_empty, bit2 tx_busy, bit3 overflow; other bits 0.
    - Write with byte_enable[0]=1 and write_data[3]=1 clears overflow.
  - 0x08 CYCLE: read returns the 32-bit free-running counter.
    - Counter increments every cycle, wraps 0xFFFFFFFF->0, and is not writable.
  - Any other offset: reads return 0, writes are ignored.
- MMIO reads have no side effects.
- FIFO:
  - Push when full: byte is dropped and overflow is set (sticky).
  - A push and a pop in the same cycle while full: pop is serviced first and the push is accepted, with no overflow.
  - A push and an overflow clear in the same cycle: set wins.
- UART FSM states: IDLE, START, DATA, STOP. Baud counter counts CLK_DIV cycles per bit.
  - IDLE: uart_tx=1. If the FIFO is non-empty, pop, latch the byte, and go to START.
  - START: uart_tx=0 for CLK_DIV cycles, then go to DATA with bit index 0.
  - DATA: uart_tx = byte[bit index], LSB first, CLK_DIV cycles per bit. After bit 7, go to STOP.
  - STOP: uart_tx=1 for CLK_DIV cycles. Then, if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Latency: push captured at posedge N with the FIFO empty and the FSM IDLE -> pop at posedge N+1 -> uart_tx low from N+1 for exactly CLK_DIV cycles. Full frame is 10*CLK_DIV cycles.
- tx_busy = (state != IDLE) | !fifo_empty.
- Reset, async, valid at any time including mid-frame:
  - uart_tx=1 immediately, state=IDLE, FIFO emptied, overflow=0, cycle counter=0, baud counter and bit index=0.
  - read_data stays combinational; RAM contents are preserved.

Decomposition:
- Shared package franken_pkg holds:
  - MMIO_TXDATA=8'h00, MMIO_STATUS=8'h04, MMIO_CYCLE=8'h08
  - STATUS bit indices (ST_FULL=0, ST_EMPTY=1, ST_BUSY=2, ST_OVF=3)
  - UART state enum (IDLE, START, DATA, STOP)
- One sub-module, franken_uart_tx: baud counter + FSM.
  - Interface: valid/ready byte input, uart_tx, busy.
  - The FIFO, RAM, decode and counter stay in the top.

Test Plan (CLK_DIV=4, FIFO_DEPTH=4):
- Store 0xDEADBEEF to 0x00000010 with byte_enable=1111, then sb 0xAA into lane 2 (byte_enable=0100, write_data=0x00AA0000) -> load of 0x10 returns 0xDEAABEEF; load of 0x00001010 (aliased, MEM_WORDS=1024) returns the same.
- Write 0x55 to TXDATA -> uart_tx low 4 cycles from the next edge, then 1,0,1,0,1,0,1,0 (4 cycles each), then high 4 cycles. Frame is 40 cycles; tx_busy deasserts after it.
- Six back-to-back TXDATA writes while busy -> 1 byte in flight + 4 queued, 6th write dropped. STATUS reads 0x0000000D (full, busy, overflow). Write STATUS 0x8 -> overflow clears. Frames follow with no idle gap.
- Read CYCLE twice, 5 cycles apart -> difference is 5. Wrap test: force counter to 0xFFFFFFFE, read after 3 cycles -> returns 1.
- Assert reset (low) 6 cycles into a frame -> uart_tx=1 asynchronously; STATUS reads 0x00000002; previously written RAM word still reads back intact.
- Read unmapped 0x80000040 -> returns 0; write to it -> no STATUS/FIFO change.
